// File: rtl/sc_fetch_pkg.sv
// Shared constants and types for the SC1 instruction-fetch front end.
package sc_fetch_pkg;

  // beq x0,x0,0 doubles as the HALT encoding.
  localparam logic [31:0] HALT_INSTR = 32'h0000_0063;
  localparam logic [31:0] PC_STEP    = 32'd4;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

endpackage : sc_fetch_pkg

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC register, IF/ID capture register, RUN/HALTED
// control, sticky misaligned-redirect flag and saturating fetch counter.
module if_fetch_unit
  import sc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall,
  input  logic             i_redirect_valid,
  input  logic [31:0]      i_redirect_target,
  output logic [31:0]      o_imem_addr,
  input  logic [31:0]      i_imem_instr,
  output logic             o_if_valid,
  output logic [31:0]      o_if_pc,
  output logic [31:0]      o_if_instr,
  output logic             o_halted,
  output logic             o_misalign_err,
  output logic [CNT_W-1:0] o_fetch_count
);

  fetch_state_t     r_state;
  logic [31:0]      r_pc;
  logic             r_if_valid;
  logic [31:0]      r_if_pc;
  logic [31:0]      r_if_instr;
  logic             r_misalign;
  logic [CNT_W-1:0] r_count;

  fetch_state_t     w_state_next;
  logic [31:0]      w_pc_next;
  logic             w_if_valid_next;
  logic [31:0]      w_if_pc_next;
  logic [31:0]      w_if_instr_next;
  logic             w_misalign_next;
  logic [CNT_W-1:0] w_count_next;
  logic [CNT_W-1:0] w_count_inc;

  // Saturating increment: stick at all-ones instead of wrapping.
  assign w_count_inc = (r_count == '1) ? r_count : r_count + CNT_W'(1);

  // Next-state logic: redirect beats stall beats HALT detection beats normal fetch.
  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_if_valid_next = r_if_valid;
    w_if_pc_next    = r_if_pc;
    w_if_instr_next = r_if_instr;
    w_misalign_next = r_misalign;
    w_count_next    = r_count;
    unique case (r_state)
      RUN: begin
        if (i_redirect_valid) begin
          w_pc_next       = {i_redirect_target[31:2], 2'b00};
          w_if_valid_next = 1'b0;
          if (i_redirect_target[1:0] != 2'b00) begin
            w_misalign_next = 1'b1;
          end
        end else if (!i_stall) begin
          w_if_valid_next = 1'b1;
          w_if_pc_next    = r_pc;
          w_if_instr_next = i_imem_instr;
          w_count_next    = w_count_inc;
          if (i_imem_instr == HALT_INSTR) begin
            // PC parks on the HALT word.
            w_state_next = HALTED;
          end else begin
            w_pc_next = r_pc + PC_STEP;
          end
        end
      end
      HALTED: begin
        w_if_valid_next = 1'b0;
      end
      default: begin
        w_state_next = RUN;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= RUN;
      r_pc       <= RESET_PC;
      r_if_valid <= 1'b0;
      r_if_pc    <= 32'h0;
      r_if_instr <= 32'h0;
      r_misalign <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_if_valid <= w_if_valid_next;
      r_if_pc    <= w_if_pc_next;
      r_if_instr <= w_if_instr_next;
      r_misalign <= w_misalign_next;
      r_count    <= w_count_next;
    end
  end

  assign o_imem_addr    = r_pc;
  assign o_if_valid     = r_if_valid;
  assign o_if_pc        = r_if_pc;
  assign o_if_instr     = r_if_instr;
  assign o_halted       = (r_state == HALTED);
  assign o_misalign_err = r_misalign;
  assign o_fetch_count  = r_count;

endmodule : if_fetch_unit

// File: tb/tb_if_fetch_unit.sv
// Directed, table-driven bench for if_fetch_unit with a small ROM model.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        rv;
  logic [31:0] tgt;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        halted;
  logic        mis;
  logic [15:0] cnt;

  // Second instance with a 4-bit counter for saturation.
  logic        rst4;
  logic        zero4;
  logic [31:0] zero_tgt;
  logic [31:0] addr4;
  logic        valid4;
  logic [31:0] pc4;
  logic [31:0] instr4;
  logic        halted4;
  logic        mis4;
  logic [3:0]  cnt4;

  int n_cmp;
  int n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0050_0093;
      32'h0000_0004: mem_word = 32'h0010_0113;
      32'h0000_0008: mem_word = 32'h0020_8193;
      32'h0000_0010: mem_word = 32'h0000_0063;
      32'h0000_0040: mem_word = 32'h00a0_0213;
      32'h0000_0044: mem_word = 32'h00b0_0293;
      default:       mem_word = 32'h0000_0013;
    endcase
  endfunction

  assign imem_instr = mem_word(imem_addr);

  if_fetch_unit dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_stall           (stall),
    .i_redirect_valid  (rv),
    .i_redirect_target (tgt),
    .o_imem_addr       (imem_addr),
    .i_imem_instr      (imem_instr),
    .o_if_valid        (if_valid),
    .o_if_pc           (if_pc),
    .o_if_instr        (if_instr),
    .o_halted          (halted),
    .o_misalign_err    (mis),
    .o_fetch_count     (cnt)
  );

  if_fetch_unit #(.CNT_W(4)) dut4 (
    .i_clk             (clk),
    .i_rst             (rst4),
    .i_stall           (zero4),
    .i_redirect_valid  (zero4),
    .i_redirect_target (zero_tgt),
    .o_imem_addr       (addr4),
    .i_imem_instr      (32'h0000_0013),
    .o_if_valid        (valid4),
    .o_if_pc           (pc4),
    .o_if_instr        (instr4),
    .o_halted          (halted4),
    .o_misalign_err    (mis4),
    .o_fetch_count     (cnt4)
  );

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] tgt;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [15:0] cnt;
    logic        halted;
    logic        mis;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] a, input logic v,
                         input logic [31:0] p, input logic [31:0] ins, input logic [15:0] c,
                         input logic h, input logic m);
    chk({tag, ".imem_addr"}, imem_addr, a);
    chk({tag, ".if_valid"}, 32'(if_valid), 32'(v));
    chk({tag, ".if_pc"}, if_pc, p);
    chk({tag, ".if_instr"}, if_instr, ins);
    chk({tag, ".fetch_count"}, 32'(cnt), 32'(c));
    chk({tag, ".halted"}, 32'(halted), 32'(h));
    chk({tag, ".misalign_err"}, 32'(mis), 32'(m));
  endtask

  task automatic step(input logic s, input logic r, input logic [31:0] t);
    stall = s;
    rv    = r;
    tgt   = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    rst4     = 1'b1;
    zero4    = 1'b0;
    zero_tgt = 32'h0;
    stall    = 1'b0;
    rv       = 1'b0;
    tgt      = 32'h0;

    //            stall rv   tgt         addr        v     pc          instr        cnt   h     mis
    vecs[0]  = '{1'b0, 1'b0, 32'h0,  32'h04, 1'b1, 32'h00, 32'h00500093, 16'd1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,  32'h08, 1'b1, 32'h04, 32'h00100113, 16'd2, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,  32'h08, 1'b1, 32'h04, 32'h00100113, 16'd2, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,  32'h08, 1'b1, 32'h04, 32'h00100113, 16'd2, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,  32'h08, 1'b1, 32'h04, 32'h00100113, 16'd2, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,  32'h0C, 1'b1, 32'h08, 32'h00208193, 16'd3, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 32'h40, 32'h40, 1'b0, 32'h08, 32'h00208193, 16'd3, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,  32'h44, 1'b1, 32'h40, 32'h00a00213, 16'd4, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 32'h42, 32'h40, 1'b0, 32'h40, 32'h00a00213, 16'd4, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,  32'h44, 1'b1, 32'h40, 32'h00a00213, 16'd5, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 32'h10, 32'h10, 1'b0, 32'h40, 32'h00a00213, 16'd5, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 32'h0,  32'h10, 1'b1, 32'h10, 32'h00000063, 16'd6, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 32'h40, 32'h10, 1'b0, 32'h10, 32'h00000063, 16'd6, 1'b1, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 32'h0,  32'h10, 1'b0, 32'h10, 32'h00000063, 16'd6, 1'b1, 1'b1};

    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_all("reset", 32'h0, 1'b0, 32'h0, 32'h0, 16'd0, 1'b0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].stall, vecs[i].rv, vecs[i].tgt);
      chk_all($sformatf("vec%0d", i), vecs[i].addr, vecs[i].valid, vecs[i].pc, vecs[i].instr,
              vecs[i].cnt, vecs[i].halted, vecs[i].mis);
    end

    // Reset while HALTED, with a redirect also pending, returns to RESET_PC.
    rst = 1'b1;
    step(1'b0, 1'b1, 32'h80);
    rst = 1'b0;
    chk_all("rst_halt", 32'h0, 1'b0, 32'h0, 32'h0, 16'd0, 1'b0, 1'b0);

    // PC wraps from the top of the address space to zero.
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    chk_all("wrap_redir", 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 16'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0);
    chk_all("wrap_fetch", 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h13, 16'd1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0);
    chk_all("wrap_next", 32'h4, 1'b1, 32'h0, 32'h00500093, 16'd2, 1'b0, 1'b0);

    // Reset beats a simultaneous redirect while running.
    rst = 1'b1;
    step(1'b0, 1'b1, 32'h41);
    rst = 1'b0;
    chk_all("rst_run", 32'h0, 1'b0, 32'h0, 32'h0, 16'd0, 1'b0, 1'b0);

    // Counter saturation on the 4-bit instance.
    rst4 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 14) chk("sat_cnt14", 32'(cnt4), 32'd14);
      if (i == 15) chk("sat_cnt15", 32'(cnt4), 32'd15);
      if (i == 20) chk("sat_cnt20", 32'(cnt4), 32'd15);
    end
    chk("sat_addr", addr4, 32'd80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_if_fetch_unit
